// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid-buffered pipeline register for a
// {data lanes, control bundle, destination tag} payload.
// in_ready comes straight from a flop, so out_ready never reaches the
// upstream side combinationally.
// Optional build macro: PIPE_PERF_CNT_EN adds a saturating stall counter port.
module pipe_skid_reg #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned CTRL_W    = 2,
  parameter int unsigned TAG_W     = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_LANES*DATA_W-1:0]   in_data,
  input  logic [CTRL_W-1:0]             in_ctrl,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic [CTRL_W-1:0]             out_ctrl,
  output logic [TAG_W-1:0]              out_tag
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0]                   perf_stall_cnt
`endif
);

  localparam int unsigned BUS_W = NUM_LANES * DATA_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              state;
  logic [BUS_W-1:0]    skid_data;
  logic [CTRL_W-1:0]   skid_ctrl;
  logic [TAG_W-1:0]    skid_tag;

  logic                accept_c;
  logic                take_c;

  // Handshake qualifiers for both sides of the stage.
  assign accept_c = in_valid & in_ready;
  assign take_c   = out_valid & out_ready;

  // State, main (output) entry and skid entry; vacated entries are zeroed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      out_tag   <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      skid_tag  <= '0;
    end else if (flush) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      out_tag   <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      skid_tag  <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept_c) begin
            state     <= S_ONE;
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_ctrl  <= in_ctrl;
            out_tag   <= in_tag;
          end
        end
        S_ONE: begin
          if (accept_c && take_c) begin
            out_data <= in_data;
            out_ctrl <= in_ctrl;
            out_tag  <= in_tag;
          end else if (accept_c) begin
            state     <= S_FULL;
            in_ready  <= 1'b0;
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            skid_tag  <= in_tag;
          end else if (take_c) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
            out_tag   <= '0;
          end
        end
        S_FULL: begin
          if (take_c) begin
            state     <= S_ONE;
            in_ready  <= 1'b1;
            out_data  <= skid_data;
            out_ctrl  <= skid_ctrl;
            out_tag   <= skid_tag;
            skid_data <= '0;
            skid_ctrl <= '0;
            skid_tag  <= '0;
          end
        end
        default: begin
          state     <= S_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_data  <= '0;
          out_ctrl  <= '0;
          out_tag   <= '0;
          skid_data <= '0;
          skid_ctrl <= '0;
          skid_tag  <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating count of cycles the presented entry is back-pressured; flush does not clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= 16'h0000;
    end else if (out_valid && !out_ready && (perf_stall_cnt != 16'hFFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (default parameters).
module tb_pipe_skid_reg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_LANES = 2;
  localparam int unsigned CTRL_W    = 2;
  localparam int unsigned TAG_W     = 5;
  localparam int unsigned BUS_W     = NUM_LANES * DATA_W;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [BUS_W-1:0]  in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [BUS_W-1:0]  out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [TAG_W-1:0]  out_tag;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0]       perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(
    .DATA_W    (DATA_W),
    .NUM_LANES (NUM_LANES),
    .CTRL_W    (CTRL_W),
    .TAG_W     (TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_tag   (out_tag)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [BUS_W-1:0] d,
                       input logic [CTRL_W-1:0] c, input logic [TAG_W-1:0] t);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
    in_tag   = t;
  endtask

  function automatic logic [BUS_W-1:0] pat_data(input int i);
    return {32'(i + 1000), ~32'(i)};
  endfunction

  localparam logic [63:0] D_A = 64'h0000_00AA_0000_0A0A;
  localparam logic [63:0] D_B = 64'h0000_00BB_0000_0B0B;
  localparam logic [63:0] D_C = 64'h0000_00CC_0000_0C0C;

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);

    // First transfer: one-cycle latency from EMPTY
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 64'h0000_0011_0000_0022, 2'b11, 5'd7);
    @(negedge clk);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_data",  64'(out_data),  64'h0000_0011_0000_0022);
    check("first_ctrl",  64'(out_ctrl),  64'd3);
    check("first_tag",   64'(out_tag),   64'd7);
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_ctrl",  64'(out_ctrl),  64'd0);

    // Back-pressure: A, B fill the stage, C waits upstream
    out_ready = 1'b0;
    drive(1'b1, D_A, 2'b01, 5'd1);
    @(negedge clk);
    check("bp_a_valid", 64'(out_valid), 64'd1);
    check("bp_a_ready", 64'(in_ready),  64'd1);
    drive(1'b1, D_B, 2'b10, 5'd2);
    @(negedge clk);
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_full_data",  64'(out_data), D_A);
    drive(1'b1, D_C, 2'b11, 5'd3);
    @(negedge clk);
    check("bp_hold_ready", 64'(in_ready), 64'd0);
    check("bp_hold_data",  64'(out_data), D_A);
    check("bp_hold_ctrl",  64'(out_ctrl), 64'd1);
    check("bp_hold_tag",   64'(out_tag),  64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("ord_b_data",  64'(out_data), D_B);
    check("ord_b_tag",   64'(out_tag),  64'd2);
    check("ord_b_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("ord_c_data",  64'(out_data), D_C);
    check("ord_c_ctrl",  64'(out_ctrl), 64'd3);
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    check("ord_empty_valid", 64'(out_valid), 64'd0);

    // Flush in FULL with a new entry offered
    out_ready = 1'b0;
    drive(1'b1, D_A, 2'b11, 5'd4);
    @(negedge clk);
    drive(1'b1, D_B, 2'b11, 5'd5);
    @(negedge clk);
    check("pre_flush_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, D_C, 2'b11, 5'd6);
    @(negedge clk);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ctrl",  64'(out_ctrl),  64'd0);
    check("flush_data",  64'(out_data),  64'd0);
    check("flush_ready", 64'(in_ready),  64'd1);
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    check("post_flush_valid", 64'(out_valid), 64'd0);

    // Streaming 100 entries at full rate
    out_ready = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) begin
        check("stream_valid", 64'(out_valid), 64'd1);
        check("stream_data",  64'(out_data),  64'(pat_data(i - 1)));
        check("stream_ctrl",  64'(out_ctrl),  64'((i - 1) % 4));
        check("stream_tag",   64'(out_tag),   64'((i - 1) % 32));
      end
      check("stream_ready", 64'(in_ready), 64'd1);
      if (i < 100) drive(1'b1, pat_data(i), CTRL_W'(i % 4), TAG_W'(i % 32));
      else         drive(1'b0, '0, '0, '0);
      @(negedge clk);
    end
    check("stream_end_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    drive(1'b1, D_A, 2'b11, 5'd9);
    @(negedge clk);
    drive(1'b1, D_B, 2'b10, 5'd10);
    @(negedge clk);
    check("areset_pre_ready", 64'(in_ready), 64'd0);
    drive(1'b0, '0, '0, '0);
    #2 reset = 1'b0;
    #1;
    check("areset_valid", 64'(out_valid), 64'd0);
    check("areset_data",  64'(out_data),  64'd0);
    check("areset_ctrl",  64'(out_ctrl),  64'd0);
    check("areset_tag",   64'(out_tag),   64'd0);
    check("areset_ready", 64'(in_ready),  64'd1);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, D_C, 2'b01, 5'd11);
    @(negedge clk);
    check("post_areset_data",  64'(out_data), D_C);
    check("post_areset_tag",   64'(out_tag),  64'd11);
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    check("post_areset_empty", 64'(out_valid), 64'd0);

`ifdef PIPE_PERF_CNT_EN
    // Stall counter: counts, saturates, survives flush, cleared by reset
    reset     = 1'b0;
    @(negedge clk);
    check("perf_rst", 64'(perf_stall_cnt), 64'd0);
    reset     = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, D_A, 2'b01, 5'd1);
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    check("perf_start", 64'(perf_stall_cnt), 64'd0);
    repeat (3) @(negedge clk);
    check("perf_three", 64'(perf_stall_cnt), 64'd3);
    repeat (70000) @(negedge clk);
    check("perf_sat", 64'(perf_stall_cnt), 64'hFFFF);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    check("perf_flush", 64'(perf_stall_cnt), 64'hFFFF);
    reset = 1'b0;
    #1;
    check("perf_clear", 64'(perf_stall_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of one data lane.
REQ-002 Parameter NUM_LANES, default 2, number of data lanes carried per entry.
REQ-003 Parameter CTRL_W, default 2, width of control-bit bundle (e.g. MemtoReg, RegWrite).
REQ-004 Parameter TAG_W, default 5, width of destination-register tag.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 reset  input  1  asynchronous, active-low reset; asserted when low.
REQ-007 flush  input  1  synchronous kill of all held entries.
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_data  input  NUM_LANES*DATA_W  flattened lanes; lane k at bits [k*DATA_W +: DATA_W].
REQ-011 in_ctrl  input  CTRL_W  control bundle.
REQ-012 in_tag  input  TAG_W  destination tag.
REQ-013 out_valid  output  1  entry presented downstream.
REQ-014 out_ready  input  1  downstream accepts this cycle.
REQ-015 out_data  output  NUM_LANES*DATA_W  held lanes.
REQ-016 out_ctrl  output  CTRL_W  held control bundle, forced to zero whenever out_valid=0.
REQ-017 out_tag  output  TAG_W  held tag.
REQ-018 perf_stall_cnt  output  16  stall counter; present only with PIPE_PERF_CNT_EN.

Function
REQ-019 accept = in_valid & in_ready; take = out_valid & out_ready; entry = {data, ctrl, tag}.
REQ-020 Two storage entries, main (drives outputs) and skid; states EMPTY (none valid), ONE (main valid), FULL (both valid).
REQ-021 in_ready = NOT skid_valid, driven directly from a register with no combinational path from out_ready.
REQ-022 out_valid = main_valid; out_data/out_ctrl/out_tag driven from main registers only.
REQ-023 EMPTY: accept -> ONE, main <= input; otherwise remain EMPTY.
REQ-024 ONE: accept & take -> ONE, main <= input; accept & !take -> FULL, skid <= input; !accept & take -> EMPTY; neither -> hold.
REQ-025 FULL: take -> ONE, main <= skid, skid cleared; !take -> hold; no accept possible (in_ready=0).
REQ-026 Latency: accepted entry appears on outputs the cycle after acceptance when stage was EMPTY or ONE with simultaneous take.
REQ-027 Throughput: one entry per cycle sustained when out_ready held high.
REQ-028 Ordering: entries leave in acceptance order; none duplicated or dropped except by flush.
REQ-029 flush has highest priority: next state EMPTY, main and skid data/ctrl/tag zeroed, input presented in flush cycle discarded, in_ready=1 the cycle after.
REQ-030 Held entries stay stable while out_valid=1 and out_ready=0.
REQ-031 Vacated entry registers are zeroed (no stale ctrl bits visible).

Reset
REQ-032 While reset=0: state EMPTY, out_valid=0, out_data=0, out_ctrl=0, out_tag=0, in_ready=1, skid contents 0, perf_stall_cnt=0.
REQ-033 Reset asserted mid-transfer discards both entries immediately; first accept after release proceeds as from EMPTY.

Configuration
REQ-034 Macro PIPE_PERF_CNT_EN defined: perf_stall_cnt port exists, increments by 1 each cycle with out_valid=1 and out_ready=0, saturates at 16'hFFFF, unaffected by flush, cleared only by reset.
REQ-035 Macro PIPE_PERF_CNT_EN undefined: port and counter logic absent; all other behaviour identical.

Verification
REQ-036 Reset release, in_valid=1 data {32'h11,32'h22} ctrl 2'b11 tag 5'd7, out_ready=1 -> next cycle out_valid=1, out_data={32'h11,32'h22}, out_ctrl=2'b11, out_tag=7.
REQ-037 out_ready=0, push A then B -> FULL, in_ready=0; third entry C held upstream; out_ready=1 -> A, B, C in order on consecutive cycles.
REQ-038 FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; in-flight entry absent from output.
REQ-039 Streaming 100 entries with out_ready=1 -> 100 outputs, in_ready never 0, values match inputs in order.
REQ-040 PIPE_PERF_CNT_EN, out_valid=1, out_ready=0 for 70000 cycles -> perf_stall_cnt=16'hFFFF; flush leaves it unchanged; reset clears to 0.
REQ-041 reset=0 asserted asynchronously between clock edges in FULL -> outputs zero and in_ready=1 before next posedge.
